// File: rtl/rsa_batch_scheduler_if.sv
// Host / store / mod-exp / consumer bundle for rsa_batch_scheduler.
// err exists only when RSA_SCHED_TIMEOUT_EN is defined.
interface rsa_batch_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              st_wr_en;
  logic [ADDR_W-1:0] st_wr_addr;
  logic              st_rd_en;
  logic [ADDR_W-1:0] st_rd_addr;
  logic [DATA_W-1:0] st_n;
  logic [DATA_W-1:0] st_d;
  logic [DATA_W-1:0] st_c;
  logic              me_start;
  logic [DATA_W-1:0] me_n;
  logic [DATA_W-1:0] me_d;
  logic [DATA_W-1:0] me_c;
  logic              me_done;
  logic [DATA_W-1:0] me_result;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_ready;
  logic              busy;
  logic [ADDR_W:0]   batch_len;
`ifdef RSA_SCHED_TIMEOUT_EN
  logic              err;
`endif

  modport master (
    input  in_valid, in_last,
    input  st_n, st_d, st_c,
    input  me_done, me_result,
    input  out_ready,
`ifdef RSA_SCHED_TIMEOUT_EN
    output err,
`endif
    output in_ready,
    output st_wr_en, st_wr_addr,
    output st_rd_en, st_rd_addr,
    output me_start, me_n, me_d, me_c,
    output out_valid, out_data, out_index,
    output busy, batch_len
  );

  modport slave (
    output in_valid, in_last,
    output st_n, st_d, st_c,
    output me_done, me_result,
    output out_ready,
`ifdef RSA_SCHED_TIMEOUT_EN
    input  err,
`endif
    input  in_ready,
    input  st_wr_en, st_wr_addr,
    input  st_rd_en, st_rd_addr,
    input  me_start, me_n, me_d, me_c,
    input  out_valid, out_data, out_index,
    input  busy, batch_len
  );
endinterface

// File: rtl/rsa_batch_scheduler.sv
// RSA decrypt batch scheduler: store control, mod-exp launch, tagged output.
// Option RSA_SCHED_TIMEOUT_EN adds a WAIT_ME watchdog and the err output.
module rsa_batch_scheduler #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic                   clk,
  input logic                   rst,
  rsa_batch_scheduler_if.master bus
);

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_WAIT_RD,
    S_LAUNCH,
    S_WAIT_ME,
    S_EMIT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [DATA_W-1:0] r_me_n;
  logic [DATA_W-1:0] r_me_d;
  logic [DATA_W-1:0] r_me_c;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_idx;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_close;
  logic [ADDR_W:0]   w_len_nxt;
  logic [ADDR_W:0]   w_ptr_inc;
  logic              w_pop;
  logic              w_done;
  logic              w_rd_en;
  logic              w_start;
  logic              w_out_valid;
  logic              w_busy;
  logic [ADDR_W-1:0] w_wr_addr;

`ifdef RSA_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;
  logic            w_tmo;
`endif

  // in_ready is forced low while rst is held, even though the state is IDLE
  assign w_in_ready = !rst &&
    ((r_state == S_IDLE) ||
     ((r_state == S_LOAD) && (r_len < L_DEPTH)));
  assign w_accept  = bus.in_valid & w_in_ready;
  assign w_len_nxt = (r_state == S_IDLE) ?
    (ADDR_W+1)'(1) : r_len + 1'b1;
  assign w_close   = w_accept &
    (bus.in_last | (w_len_nxt == L_DEPTH));
  assign w_ptr_inc = {1'b0, r_rd_ptr} + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_wr_addr   = '0;
    w_rd_en     = 1'b0;
    w_start     = 1'b0;
    w_out_valid = 1'b0;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_busy      = 1'b1;
`ifdef RSA_SCHED_TIMEOUT_EN
    w_tmo       = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_accept)
          w_next = w_close ? S_FETCH : S_LOAD;
      end
      S_LOAD: begin
        w_wr_addr = r_len[ADDR_W-1:0];
        if (w_accept && w_close)
          w_next = S_FETCH;
      end
      S_FETCH: begin
        w_rd_en = 1'b1;
        w_next  = S_WAIT_RD;
      end
      S_WAIT_RD: w_next = S_LAUNCH;
      S_LAUNCH: begin
        w_start = 1'b1;
        w_next  = S_WAIT_ME;
      end
      S_WAIT_ME: begin
        if (bus.me_done) begin
          w_done = 1'b1;
          w_next = S_EMIT;
        end
`ifdef RSA_SCHED_TIMEOUT_EN
        else if (r_to_cnt == TO_LAST) begin
          w_tmo  = 1'b1;
          w_next = S_EMIT;
        end
`endif
      end
      S_EMIT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_pop  = 1'b1;
          w_next = (w_ptr_inc == r_len) ? S_IDLE : S_FETCH;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= '0;
      r_rd_ptr   <= '0;
      r_me_n     <= '0;
      r_me_d     <= '0;
      r_me_c     <= '0;
      r_out_data <= '0;
      r_out_idx  <= '0;
    end else begin
      if (w_accept) r_len <= w_len_nxt;
      if (w_close)  r_rd_ptr <= '0;
      else if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (r_state == S_WAIT_RD) begin
        r_me_n <= bus.st_n;
        r_me_d <= bus.st_d;
        r_me_c <= bus.st_c;
      end
      if (w_done) begin
        r_out_data <= bus.me_result;
        r_out_idx  <= r_rd_ptr;
      end
`ifdef RSA_SCHED_TIMEOUT_EN
      else if (w_tmo) begin
        r_out_data <= '0;
        r_out_idx  <= r_rd_ptr;
      end
`endif
    end
  end

`ifdef RSA_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH)       r_to_cnt <= '0;
      else if (r_state == S_WAIT_ME) r_to_cnt <= r_to_cnt + 1'b1;
      if (w_done)     r_err <= 1'b0;
      else if (w_tmo) r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`endif

  assign bus.in_ready   = w_in_ready;
  assign bus.st_wr_en   = w_accept;
  assign bus.st_wr_addr = w_wr_addr;
  assign bus.st_rd_en   = w_rd_en;
  assign bus.st_rd_addr = r_rd_ptr;
  assign bus.me_start   = w_start;
  assign bus.me_n       = r_me_n;
  assign bus.me_d       = r_me_d;
  assign bus.me_c       = r_me_c;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_index  = r_out_idx;
  assign bus.busy       = w_busy;
  assign bus.batch_len  = r_len;

endmodule

// File: tb/tb_rsa_batch_scheduler.sv
// Bench for rsa_batch_scheduler: tuple store and mod-exp unit models,
// expected plaintexts computed by square-and-multiply on host tuples.
module tb_rsa_batch_scheduler;

`ifdef RSA_SCHED_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rsa_batch_scheduler_if #(.DATA_W(32), .ADDR_W(5)) bif ();

  rsa_batch_scheduler #(
    .DATA_W(32), .DEPTH(32), .ADDR_W(5), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  typedef struct {
    logic [31:0] data;
    int          idx;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tn [32];
  logic [31:0] td [32];
  logic [31:0] tc [32];
  logic [31:0] h_n, h_d, h_c;
  logic [31:0] mem_n [32];
  logic [31:0] mem_d [32];
  logic [31:0] mem_c [32];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int close_cyc = 0;
  int done_cyc = 0;
  int n_start = 0;
  int n_rd = 0;
  int me_lat = 5;
  bit me_never = 0;

  function automatic logic [31:0] modexp(
    input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    logic [63:0] r, x, mm;
    mm = {32'd0, m};
    r = 64'd1 % mm;
    x = {32'd0, b} % mm;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[31:0];
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bif.me_start) n_start <= n_start + 1;
    if (bif.st_rd_en) n_rd <= n_rd + 1;
  end

  // Tuple store: write from host data, registered read.
  always @(posedge clk) begin
    if (bif.st_wr_en) begin
      mem_n[bif.st_wr_addr] <= h_n;
      mem_d[bif.st_wr_addr] <= h_d;
      mem_c[bif.st_wr_addr] <= h_c;
    end
    if (bif.st_rd_en) begin
      bif.st_n <= mem_n[bif.st_rd_addr];
      bif.st_d <= mem_d[bif.st_rd_addr];
      bif.st_c <= mem_c[bif.st_rd_addr];
    end
  end

  // Mod-exp unit: one job at a time, result after me_lat cycles.
  initial begin
    logic [31:0] res;
    int lat;
    bif.me_done = 1'b0;
    bif.me_result = 32'hdeadbeef;
    forever begin
      @(negedge clk);
      if (!(bif.me_start && !rst)) continue;
      res = modexp(bif.me_c, bif.me_d, bif.me_n);
      if (me_never) continue;
      lat = (me_lat == 0) ? int'($urandom_range(1, 6)) : me_lat;
      repeat (lat) @(negedge clk);
      bif.me_done = 1'b1;
      bif.me_result = res;
      done_cyc = cyc;
      @(negedge clk);
      bif.me_done = 1'b0;
      bif.me_result = 32'hdeadbeef;
    end
  end

  task automatic send_batch(input int len, input bit use_last,
                            input bit gaps, input bit linger);
    int k = 0;
    int budget = 0;
    exp_q.delete();
    while (k < len && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bif.in_valid = 1'b0;
        bif.in_last = 1'b0;
        continue;
      end
      h_n = tn[k];
      h_d = td[k];
      h_c = tc[k];
      bif.in_valid = 1'b1;
      bif.in_last = use_last && (k == len - 1);
      #1;
      chk("in_ready", bif.in_ready, 1);
      chk("wr_en", bif.st_wr_en, 1);
      chk("wr_addr", bif.st_wr_addr, k);
      exp_q.push_back('{modexp(tc[k], td[k], tn[k]), k});
      if (k == len - 1) close_cyc = cyc;
      k++;
    end
    if (k < len) chk("send_timeout", k, len);
    @(negedge clk);
    bif.in_last = 1'b0;
    bif.in_valid = linger;
    #1;
    chk("closed_ready", bif.in_ready, 0);
    chk("closed_wr", bif.st_wr_en, 0);
  endtask

  task automatic drain(input int stall_at, input bit rnd);
    int n = exp_q.size();
    int got = 0;
    int budget = 0;
    int stall = 0;
    int st0 = n_start;
    int rd0 = n_rd;
    bit fresh = 1;
    bit held = 0;
    bit pend = 1;
    while (got < n && budget < 5000) begin
      @(negedge clk);
      budget++;
      bif.out_ready = 1'b0;
      chk("no_wr", bif.st_wr_en, 0);
      if (held) chk("hold_valid", bif.out_valid, 1);
      held = 0;
      if (pend && bif.me_start) begin
        chk("start_lat", cyc - close_cyc, 3);
        pend = 0;
      end
      if (bif.out_valid) begin
        if (fresh) chk("done_lat", cyc - done_cyc, 1);
        fresh = 0;
        chk("out_data", bif.out_data, exp_q[0].data);
        chk("out_index", bif.out_index, exp_q[0].idx);
`ifdef RSA_SCHED_TIMEOUT_EN
        chk("err_clear", bif.err, 0);
`endif
        if (got == stall_at && stall < 10) begin
          stall++;
          held = 1;
          chk("stall_rd", bif.st_rd_en, 0);
          chk("stall_start", bif.me_start, 0);
        end else if (rnd && $urandom_range(0, 2) == 0) begin
          held = 1;
        end else begin
          bif.out_ready = 1'b1;
          void'(exp_q.pop_front());
          got++;
          fresh = 1;
        end
      end
    end
    if (got < n) chk("drain_timeout", got, n);
    bif.in_valid = 1'b0;
    @(negedge clk);
    bif.out_ready = 1'b0;
    chk("n_start", n_start - st0, n);
    chk("n_rd", n_rd - rd0, n);
    chk("idle_busy", bif.busy, 0);
    chk("idle_ready", bif.in_ready, 1);
    chk("batch_len", bif.batch_len, n);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, bif.busy, 0);
    chk({tag, "_ovalid"}, bif.out_valid, 0);
    chk({tag, "_rd_en"}, bif.st_rd_en, 0);
    chk({tag, "_start"}, bif.me_start, 0);
    chk({tag, "_len"}, bif.batch_len, 0);
    chk({tag, "_me_n"}, bif.me_n, 0);
    chk({tag, "_me_c"}, bif.me_c, 0);
    chk({tag, "_odata"}, bif.out_data, 0);
    chk({tag, "_oidx"}, bif.out_index, 0);
    chk({tag, "_rd_addr"}, bif.st_rd_addr, 0);
    chk({tag, "_wr_addr"}, bif.st_wr_addr, 0);
  endtask

  initial begin
    int s;
    int v;
    int len;
    bif.in_valid = 1'b0;
    bif.in_last = 1'b0;
    bif.out_ready = 1'b0;
    h_n = '0;
    h_d = '0;
    h_c = '0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", bif.in_ready, 0);
    chk("rst_wr_en", bif.st_wr_en, 0);
    chk_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready0", bif.in_ready, 1);

    tn[0] = 33; td[0] = 7; tc[0] = 31;
    send_batch(1, 1, 0, 0);
    drain(-1, 0);

    for (int i = 0; i < 3; i++) begin
      tn[i] = 33;
      td[i] = 7;
    end
    tc[0] = 31; tc[1] = 1; tc[2] = 0;
    send_batch(3, 1, 0, 0);
    drain(-1, 0);

    me_lat = 2;
    for (int i = 0; i < 32; i++) begin
      tn[i] = $urandom | 32'h1;
      td[i] = $urandom;
      tc[i] = $urandom;
    end
    send_batch(32, 0, 0, 1);
    drain(5, 0);

    me_lat = 0;
    for (int b = 0; b < 4; b++) begin
      len = $urandom_range(1, 32);
      for (int i = 0; i < 32; i++) begin
        tn[i] = $urandom;
        if (tn[i] == 0) tn[i] = 1;
        td[i] = $urandom;
        tc[i] = $urandom;
      end
      send_batch(len, (len < 32) ? 1'b1 : 1'($urandom_range(0, 1)), 1, 0);
      drain(-1, 1);
    end

    me_lat = 2;
    tn[0] = 33; td[0] = 7; tc[0] = 31;
    send_batch(1, 1, 0, 0);
    s = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bif.me_start) begin
        s = cyc;
        break;
      end
    end
    chk("rst_start_seen", (s >= 0), 1);
    @(negedge clk);
    chk("wait_me_busy", bif.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", bif.in_ready, 0);
    chk_reset_vals("midrst");
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_reset_vals("postrst");
      chk("postrst_ready", bif.in_ready, 1);
    end

`ifdef RSA_SCHED_TIMEOUT_EN
    me_never = 1;
    tn[0] = 33; td[0] = 7; tc[0] = 31;
    send_batch(1, 1, 0, 0);
    s = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bif.me_start) begin
        s = cyc;
        break;
      end
    end
    chk("to_start_seen", (s >= 0), 1);
    v = -1;
    for (int k = 0; k < 4 * TO; k++) begin
      @(negedge clk);
      if (bif.out_valid) begin
        v = cyc;
        break;
      end
    end
    chk("to_lat", v - s, TO + 1);
    chk("to_data", bif.out_data, 0);
    chk("to_err", bif.err, 1);
    chk("to_index", bif.out_index, 0);
    bif.out_ready = 1'b1;
    @(negedge clk);
    bif.out_ready = 1'b0;
    me_never = 0;
    exp_q.delete();
    chk("to_idle", bif.busy, 0);
    send_batch(1, 1, 0, 0);
    drain(-1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
